axi4_protocol_checker: RTL and testbench

Parametrised passive AXI4 monitor/checker that sits beside the memory-mapped slave on the same bus signals and replaces plain handshake logging with cycle-accurate protocol checking. It tracks one outstanding write and one outstanding read burst, counts beats against AxLEN, checks VALID/payload stability and stall timeouts, and reports sticky error flags plus completed-transaction counters to the testbench scoreboard. It never drives bus signals.

---
 rtl/axi4_protocol_checker.sv | 225 ++++++++++++++++++++++
 tb/tb_axi4_protocol_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_protocol_checker.sv
// Passive AXI4 protocol checker: tracks one write and one read burst, checks
// beat counts, VALID/payload stability and stall timeouts, reports sticky flags.
module axi4_protocol_checker #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int LEN_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  AWVALID,
   input  logic                  AWREADY,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic [LEN_WIDTH-1:0]  AWLEN,
   input  logic                  WVALID,
   input  logic                  WREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  WLAST,
   input  logic                  BVALID,
   input  logic                  BREADY,
   input  logic [1:0]            BRESP,
   input  logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic [LEN_WIDTH-1:0]  ARLEN,
   input  logic                  RVALID,
   input  logic                  RREADY,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic                  RLAST,
   input  logic [1:0]            RRESP,
   input  logic                  err_clr,
   output logic [7:0]            err_flags,
   output logic                  err_pulse,
   output logic                  wr_busy,
   output logic                  rd_busy,
   output logic [CNT_WIDTH-1:0]  wr_done_cnt,
   output logic [CNT_WIDTH-1:0]  rd_done_cnt
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   wr_state_t                  wr_state_q, wr_state_d;
   rd_state_t                  rd_state_q, rd_state_d;
   logic [LEN_WIDTH-1:0]       w_len_q, w_len_d, w_beat_q, w_beat_d;
   logic [LEN_WIDTH-1:0]       r_len_q, r_len_d, r_beat_q, r_beat_d;
   logic [4:0]                 stall_q, stall_d;
   logic [4:0][TW-1:0]         tcnt_q, tcnt_d;
   logic [ADDR_WIDTH+LEN_WIDTH-1:0] aw_pl_q, aw_pl_d, ar_pl_q, ar_pl_d;
   logic [DATA_WIDTH:0]        w_pl_q, w_pl_d;
   logic [1:0]                 b_pl_q, b_pl_d;
   logic [DATA_WIDTH+2:0]      r_pl_q, r_pl_d;
   logic [7:0]                 err_flags_q, err_flags_d, new_err;
   logic                       err_pulse_q, err_pulse_d;
   logic                       wr_busy_q, wr_busy_d, rd_busy_q, rd_busy_d;
   logic [CNT_WIDTH-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic                       aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign b_hs  = BVALID && BREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID && RREADY;

   assign stall_d = {RVALID && !RREADY, ARVALID && !ARREADY, BVALID && !BREADY,
                     WVALID && !WREADY, AWVALID && !AWREADY};
   assign aw_pl_d = {AWADDR, AWLEN};
   assign w_pl_d  = {WDATA, WLAST};
   assign b_pl_d  = BRESP;
   assign ar_pl_d = {ARADDR, ARLEN};
   assign r_pl_d  = {RDATA, RLAST, RRESP};

   always_comb begin
      wr_state_d = wr_state_q;
      rd_state_d = rd_state_q;
      w_len_d    = w_len_q;
      w_beat_d   = w_beat_q;
      r_len_d    = r_len_q;
      r_beat_d   = r_beat_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      tcnt_d     = tcnt_q;
      new_err    = '0;

      case (wr_state_q)
         W_IDLE: begin
            if (BVALID) new_err[4] = 1'b1;
            if (w_hs)   new_err[5] = 1'b1;
            if (aw_hs) begin
               wr_state_d = W_DATA;
               w_len_d    = AWLEN;
               w_beat_d   = '0;
            end
         end
         W_DATA: begin
            if (BVALID) new_err[4] = 1'b1;
            if (aw_hs)  new_err[5] = 1'b1;
            if (w_hs) begin
               if (w_beat_q == w_len_q) begin
                  if (!WLAST) new_err[1] = 1'b1;
                  wr_state_d = W_RESP;
               end else if (WLAST) begin
                  new_err[0] = 1'b1;
                  wr_state_d = W_RESP;
               end else begin
                  w_beat_d = w_beat_q + 1'b1;
               end
            end
         end
         W_RESP: begin
            if (aw_hs || w_hs) new_err[5] = 1'b1;
            if (b_hs) begin
               wr_state_d = W_IDLE;
               if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase

      case (rd_state_q)
         R_IDLE: begin
            if (RVALID) new_err[4] = 1'b1;
            if (ar_hs) begin
               rd_state_d = R_DATA;
               r_len_d    = ARLEN;
               r_beat_d   = '0;
            end
         end
         R_DATA: begin
            if (ar_hs) new_err[5] = 1'b1;
            if (r_hs) begin
               if (r_beat_q == r_len_q) begin
                  if (!RLAST) new_err[3] = 1'b1;
                  rd_state_d = R_IDLE;
                  if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
               end else if (RLAST) begin
                  new_err[2] = 1'b1;
                  rd_state_d = R_IDLE;
               end else begin
                  r_beat_d = r_beat_q + 1'b1;
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase

      // a stall seen at the previous edge must persist with identical payload
      if ((stall_q[0] && (!AWVALID || aw_pl_d != aw_pl_q)) ||
          (stall_q[1] && (!WVALID  || w_pl_d  != w_pl_q))  ||
          (stall_q[2] && (!BVALID  || b_pl_d  != b_pl_q))  ||
          (stall_q[3] && (!ARVALID || ar_pl_d != ar_pl_q)) ||
          (stall_q[4] && (!RVALID  || r_pl_d  != r_pl_q)))
         new_err[6] = 1'b1;

      for (int unsigned i = 0; i < 5; i++) begin
         if (!stall_d[i]) begin
            tcnt_d[i] = '0;
         end else if (tcnt_q[i] != TMAX) begin
            tcnt_d[i] = tcnt_q[i] + 1'b1;
            if (tcnt_d[i] == TMAX) new_err[7] = 1'b1;
         end
      end

      err_flags_d = (err_clr ? 8'h00 : err_flags_q) | new_err;
      err_pulse_d = |(new_err & ~err_flags_q);
      wr_busy_d   = (wr_state_d != W_IDLE);
      rd_busy_d   = (rd_state_d != R_IDLE);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_state_q  <= W_IDLE;
         rd_state_q  <= R_IDLE;
         w_len_q     <= '0;
         w_beat_q    <= '0;
         r_len_q     <= '0;
         r_beat_q    <= '0;
         stall_q     <= '0;
         tcnt_q      <= '0;
         aw_pl_q     <= '0;
         w_pl_q      <= '0;
         b_pl_q      <= '0;
         ar_pl_q     <= '0;
         r_pl_q      <= '0;
         err_flags_q <= '0;
         err_pulse_q <= 1'b0;
         wr_busy_q   <= 1'b0;
         rd_busy_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
      end else begin
         wr_state_q  <= wr_state_d;
         rd_state_q  <= rd_state_d;
         w_len_q     <= w_len_d;
         w_beat_q    <= w_beat_d;
         r_len_q     <= r_len_d;
         r_beat_q    <= r_beat_d;
         stall_q     <= stall_d;
         tcnt_q      <= tcnt_d;
         aw_pl_q     <= aw_pl_d;
         w_pl_q      <= w_pl_d;
         b_pl_q      <= b_pl_d;
         ar_pl_q     <= ar_pl_d;
         r_pl_q      <= r_pl_d;
         err_flags_q <= err_flags_d;
         err_pulse_q <= err_pulse_d;
         wr_busy_q   <= wr_busy_d;
         rd_busy_q   <= rd_busy_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
      end
   end

   assign err_flags   = err_flags_q;
   assign err_pulse   = err_pulse_q;
   assign wr_busy     = wr_busy_q;
   assign rd_busy     = rd_busy_q;
   assign wr_done_cnt = wr_cnt_q;
   assign rd_done_cnt = rd_cnt_q;

endmodule

// File: tb/tb_axi4_protocol_checker.sv
// Bench for axi4_protocol_checker: directed protocol scenarios plus random bus
// traffic, scored against a transaction-level model through an expectation queue.
module tb_axi4_protocol_checker;
   localparam int DW = 32, AWD = 10, LW = 8, TO = 16, CW = 16;

   logic ACLK = 1'b0;
   logic ARESET;
   logic AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
   logic ARVALID, ARREADY, RVALID, RREADY, RLAST, err_clr;
   logic [AWD-1:0] AWADDR, ARADDR;
   logic [LW-1:0]  AWLEN, ARLEN;
   logic [DW-1:0]  WDATA, RDATA;
   logic [1:0]     BRESP, RRESP;
   logic [7:0]     err_flags;
   logic           err_pulse, wr_busy, rd_busy;
   logic [CW-1:0]  wr_done_cnt, rd_done_cnt;

   always #5 ACLK = ~ACLK;

   axi4_protocol_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .LEN_WIDTH(LW),
                           .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
      .err_clr(err_clr), .err_flags(err_flags), .err_pulse(err_pulse),
      .wr_busy(wr_busy), .rd_busy(rd_busy),
      .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt));

   typedef struct {
      logic [7:0] flags;
      logic       pulse, wb, rb;
      int         wc, rc;
   } exp_t;

   exp_t q[$];
   int errors = 0, checks = 0;

   // Model: remaining beats of the open burst; -1 = none open, 0 = awaiting B
   int w_left = -1, r_left = -1, wcnt = 0, rcnt = 0;
   logic [7:0] m_flags = 8'h00;
   int run[5];
   logic [4:0] pv_st = '0;
   logic [AWD+LW-1:0] p_aw, p_ar;
   logic [DW:0]       p_w;
   logic [1:0]        p_b;
   logic [DW+2:0]     p_r;

   function automatic void chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
      end
   endfunction

   task automatic model_step();
      exp_t e;
      logic [7:0] nw;
      logic [4:0] vld, st, chg;
      int rem;
      nw = 8'h00;
      if (ARESET) begin
         w_left = -1; r_left = -1; wcnt = 0; rcnt = 0; m_flags = 8'h00; pv_st = '0;
         for (int i = 0; i < 5; i++) run[i] = 0;
         e.flags = 8'h00; e.pulse = 1'b0; e.wb = 1'b0; e.rb = 1'b0; e.wc = 0; e.rc = 0;
         q.push_back(e);
         return;
      end
      if (w_left == -1) begin
         if (BVALID) nw[4] = 1'b1;
         if (WVALID && WREADY) nw[5] = 1'b1;
         if (AWVALID && AWREADY) w_left = int'(AWLEN) + 1;
      end else if (w_left > 0) begin
         if (BVALID) nw[4] = 1'b1;
         if (AWVALID && AWREADY) nw[5] = 1'b1;
         if (WVALID && WREADY) begin
            rem = w_left - 1;
            if (rem == 0 && !WLAST) nw[1] = 1'b1;
            if (rem > 0 && WLAST) nw[0] = 1'b1;
            w_left = (WLAST || rem == 0) ? 0 : rem;
         end
      end else begin
         if ((AWVALID && AWREADY) || (WVALID && WREADY)) nw[5] = 1'b1;
         if (BVALID && BREADY) begin
            w_left = -1;
            if (wcnt < 65535) wcnt++;
         end
      end
      if (r_left == -1) begin
         if (RVALID) nw[4] = 1'b1;
         if (ARVALID && ARREADY) r_left = int'(ARLEN) + 1;
      end else begin
         if (ARVALID && ARREADY) nw[5] = 1'b1;
         if (RVALID && RREADY) begin
            rem = r_left - 1;
            if (rem == 0) begin
               if (!RLAST) nw[3] = 1'b1;
               if (rcnt < 65535) rcnt++;
               r_left = -1;
            end else if (RLAST) begin
               nw[2] = 1'b1;
               r_left = -1;
            end else begin
               r_left = rem;
            end
         end
      end
      vld = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
      st  = {RVALID && !RREADY, ARVALID && !ARREADY, BVALID && !BREADY,
             WVALID && !WREADY, AWVALID && !AWREADY};
      chg = {({RDATA, RLAST, RRESP} != p_r), ({ARADDR, ARLEN} != p_ar),
             (BRESP != p_b), ({WDATA, WLAST} != p_w), ({AWADDR, AWLEN} != p_aw)};
      for (int i = 0; i < 5; i++)
         if (pv_st[i] && (!vld[i] || chg[i])) nw[6] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (!st[i]) run[i] = 0;
         else if (run[i] < TO) begin
            run[i]++;
            if (run[i] == TO) nw[7] = 1'b1;
         end
      end
      e.pulse = |(nw & ~m_flags);
      m_flags = (err_clr ? 8'h00 : m_flags) | nw;
      pv_st = st;
      p_aw = {AWADDR, AWLEN}; p_ar = {ARADDR, ARLEN}; p_w = {WDATA, WLAST};
      p_b = BRESP; p_r = {RDATA, RLAST, RRESP};
      e.flags = m_flags; e.wb = (w_left != -1); e.rb = (r_left != -1);
      e.wc = wcnt; e.rc = rcnt;
      q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge ACLK);
      model_step();
      @(negedge ACLK);
   endtask

   task automatic idle();
      AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; BVALID = 0; BREADY = 0;
      ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; err_clr = 0;
   endtask

   task automatic clear();
      err_clr = 1; cyc(); err_clr = 0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge ACLK);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("err_flags", err_flags, e.flags);
            chk("err_pulse", err_pulse, e.pulse);
            chk("wr_busy", wr_busy, e.wb);
            chk("rd_busy", rd_busy, e.rb);
            chk("wr_done_cnt", wr_done_cnt, e.wc);
            chk("rd_done_cnt", rd_done_cnt, e.rc);
         end
      end
   end

   initial begin : stim
      ARESET = 1; idle();
      AWADDR = '0; AWLEN = '0; WDATA = '0; WLAST = 0; BRESP = '0;
      ARADDR = '0; ARLEN = '0; RDATA = '0; RLAST = 0; RRESP = '0;
      cyc(); cyc();
      chk("reset_flags", err_flags, 0);
      chk("reset_busy", {wr_busy, rd_busy}, 0);
      ARESET = 0;

      // clean 4-beat write
      AWVALID = 1; AWREADY = 1; AWADDR = 10'h040; AWLEN = 8'd3; cyc();
      AWVALID = 0; AWREADY = 0;
      for (int b = 0; b < 4; b++) begin
         WVALID = 1; WREADY = 1; WDATA = $urandom; WLAST = (b == 3); cyc();
      end
      WVALID = 0; WREADY = 0; BVALID = 1; BREADY = 1; BRESP = 2'b00; cyc();
      BVALID = 0; BREADY = 0;
      chk("t1_flags", err_flags, 0);
      chk("t1_wr_done", wr_done_cnt, 1);
      chk("t1_wr_busy", wr_busy, 0);

      // read with early RLAST, then a stray beat
      ARVALID = 1; ARREADY = 1; ARADDR = 10'h100; ARLEN = 8'd3; cyc();
      ARVALID = 0; ARREADY = 0;
      RVALID = 1; RREADY = 1; RLAST = 0; RDATA = $urandom; cyc();
      RLAST = 1; RDATA = $urandom; cyc();
      chk("t2_early_flags", err_flags, 8'h04);
      chk("t2_early_pulse", err_pulse, 1);
      chk("t2_rd_busy", rd_busy, 0);
      RLAST = 0; cyc();
      chk("t2_stray_flags", err_flags, 8'h14);
      RVALID = 0; RREADY = 0; cyc();
      chk("t2_pulse_drop", err_pulse, 0);
      clear();
      chk("t2_cleared", err_flags, 0);

      // AW address changes while stalled
      AWVALID = 1; AWREADY = 0; AWADDR = 10'h010; AWLEN = 8'd0; cyc();
      AWADDR = 10'h014; cyc();
      chk("t3_stability", err_flags, 8'h40);
      AWREADY = 1; cyc();
      AWVALID = 0; AWREADY = 0;
      WVALID = 1; WREADY = 1; WLAST = 1; cyc();
      WVALID = 0; WREADY = 0; BVALID = 1; BREADY = 1; cyc();
      BVALID = 0; BREADY = 0; clear();

      // AR stall timeout
      ARVALID = 1; ARREADY = 0; ARADDR = 10'h200; ARLEN = 8'd0;
      for (int i = 0; i < TO - 1; i++) cyc();
      chk("t4_no_timeout_yet", err_flags, 0);
      cyc();
      chk("t4_timeout_flags", err_flags, 8'h80);
      chk("t4_timeout_pulse", err_pulse, 1);
      cyc();
      chk("t4_pulse_once", err_pulse, 0);
      ARREADY = 1; cyc();
      ARVALID = 0; ARREADY = 0;
      RVALID = 1; RREADY = 1; RLAST = 1; cyc();
      RVALID = 0; RREADY = 0; RLAST = 0;
      chk("t4_rd_done", rd_done_cnt, 1);
      clear();

      // unexpected B, then clear racing WLAST_MISSING
      BVALID = 1; BREADY = 1; cyc();
      BVALID = 0; BREADY = 0;
      chk("t5_unexp", err_flags, 8'h10);
      AWVALID = 1; AWREADY = 1; AWLEN = 8'd0; cyc();
      AWVALID = 0; AWREADY = 0;
      WVALID = 1; WREADY = 1; WLAST = 0; err_clr = 1; cyc();
      WVALID = 0; WREADY = 0; err_clr = 0;
      chk("t5_clr_vs_set", err_flags, 8'h02);
      BVALID = 1; BREADY = 1; cyc();
      BVALID = 0; BREADY = 0;

      // asynchronous reset mid-burst
      AWVALID = 1; AWREADY = 1; AWLEN = 8'd3; cyc();
      AWVALID = 0; AWREADY = 0;
      WVALID = 1; WREADY = 1; WLAST = 0; cyc(); cyc();
      WVALID = 0; WREADY = 0;
      ARESET = 1;
      #1;
      chk("t6_async_flags", err_flags, 0);
      chk("t6_async_busy", {wr_busy, rd_busy, err_pulse}, 0);
      chk("t6_async_cnts", {wr_done_cnt, rd_done_cnt}, 0);
      cyc();
      ARESET = 0;
      AWVALID = 1; AWREADY = 1; AWLEN = 8'd0; cyc();
      AWVALID = 0; AWREADY = 0;
      WVALID = 1; WREADY = 1; WLAST = 1; cyc();
      WVALID = 0; WREADY = 0; BVALID = 1; BREADY = 1; cyc();
      BVALID = 0; BREADY = 0;
      chk("t6_wr_done", wr_done_cnt, 1);
      chk("t6_flags", err_flags, 0);

      // random traffic, with periodic ready-starved windows to reach timeouts
      for (int n = 0; n < 3000; n++) begin
         automatic bit starve = (n % 500) < 20;
         AWVALID = ($urandom_range(0, 1) == 1);
         WVALID  = ($urandom_range(0, 1) == 1);
         BVALID  = ($urandom_range(0, 2) == 0);
         ARVALID = ($urandom_range(0, 1) == 1);
         RVALID  = ($urandom_range(0, 1) == 1);
         AWREADY = !starve && ($urandom_range(0, 3) != 0);
         WREADY  = !starve && ($urandom_range(0, 3) != 0);
         BREADY  = !starve && ($urandom_range(0, 3) != 0);
         ARREADY = !starve && ($urandom_range(0, 3) != 0);
         RREADY  = !starve && ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) AWADDR = AWD'($urandom);
         if ($urandom_range(0, 3) == 0) AWLEN = LW'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) ARADDR = AWD'($urandom);
         if ($urandom_range(0, 3) == 0) ARLEN = LW'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) WDATA = $urandom;
         if ($urandom_range(0, 3) == 0) RDATA = $urandom;
         if ($urandom_range(0, 3) == 0) BRESP = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) RRESP = 2'($urandom_range(0, 3));
         WLAST = ($urandom_range(0, 2) == 0);
         RLAST = ($urandom_range(0, 2) == 0);
         err_clr = starve ? 1'b0 : ($urandom_range(0, 3) == 0);
         cyc();
      end
      idle();
      cyc(); cyc();

      for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge ACLK);
      chk("scoreboard_drain", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
